// File: rtl/borrow_skip_pkg.sv
// Shared types and slice geometry for the borrow-skip subtractor.
// No logic here: state encoding and slice/group widths only.
package borrow_skip_pkg;
  localparam int SLICE_W = 8;
  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/borrow_skip_group4.sv
// Combinational 4-bit borrow-skip subtract group, zero latency, no handshake.
// When every bit propagates, the group borrow-in bypasses the ripple chain.
module borrow_skip_group4
  import borrow_skip_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               bin,
  output logic [GROUP_W-1:0] d,
  output logic               bout,
  output logic               pg
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   br;

  always_comb begin
    p     = ~(a ^ b);
    g     = ~a & b;
    br[0] = bin;
    for (int i = 0; i < GROUP_W; i++) begin
      br[i+1] = g[i] | (p[i] & br[i]);
    end
    d    = a ^ b ^ br[GROUP_W-1:0];
    pg   = &p;
    bout = pg ? bin : br[GROUP_W];
  end

endmodule

// File: rtl/borrow_skip_subtractor.sv
// Multi-cycle a - b - bin, one 8-bit slice per cycle; accept-to-out_valid is N+1 cycles.
// Result is held with out_valid until out_ready; no new operands are taken until then.
module borrow_skip_subtractor
  import borrow_skip_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] a_sl, b_sl, d_sl;
  logic               br_mid, br_hi, pg_lo, pg_hi, br_slice;
  logic [WIDTH-1:0]   acc_full;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IDX_W'(s)) begin
        a_sl = a_q[s*SLICE_W +: SLICE_W];
        b_sl = b_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  borrow_skip_group4 u_grp_lo (
    .a    (a_sl[GROUP_W-1:0]),
    .b    (b_sl[GROUP_W-1:0]),
    .bin  (br_q),
    .d    (d_sl[GROUP_W-1:0]),
    .bout (br_mid),
    .pg   (pg_lo)
  );

  borrow_skip_group4 u_grp_hi (
    .a    (a_sl[SLICE_W-1:GROUP_W]),
    .b    (b_sl[SLICE_W-1:GROUP_W]),
    .bin  (br_mid),
    .d    (d_sl[SLICE_W-1:GROUP_W]),
    .bout (br_hi),
    .pg   (pg_hi)
  );

  // Second skip level: a fully propagating slice passes the incoming borrow straight out.
  assign br_slice = (pg_lo & pg_hi) ? br_q : br_hi;

  always_comb begin
    acc_full = acc_q;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IDX_W'(s)) begin
        acc_full[s*SLICE_W +: SLICE_W] = d_sl;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    br_d        = br_q;
    acc_d       = acc_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_full;
        br_d  = br_slice;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          diff_d      = acc_full;
          bout_d      = br_slice;
          zero_d      = (acc_full == '0);
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (acc_full[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      acc_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      br_q        <= br_d;
      acc_q       <= acc_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// Bench for borrow_skip_subtractor at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_borrow_skip_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel8, in_valid, out_ready, bin;
  logic [31:0] a, b;

  logic        ir32, ov32, bo32, z32, of32;
  logic [31:0] d32;
  logic        ir8, ov8, bo8, z8, of8;
  logic [7:0]  d8;
  logic        iv32, iv8, or32, or8;

  assign iv32 = in_valid & ~sel8;
  assign iv8  = in_valid & sel8;
  assign or32 = out_ready & ~sel8;
  assign or8  = out_ready & sel8;

  borrow_skip_subtractor #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b), .bin(bin),
    .out_valid(ov32), .out_ready(or32), .diff(d32), .bout(bo32), .zero(z32), .ovf(of32)
  );

  borrow_skip_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]), .bin(bin),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .zero(z8), .ovf(of8)
  );

  wire        in_ready_v  = sel8 ? ir8 : ir32;
  wire        out_valid_v = sel8 ? ov8 : ov32;
  wire [31:0] diff_v      = sel8 ? {24'h0, d8} : d32;
  wire        bout_v      = sel8 ? bo8 : bo32;
  wire        zero_v      = sel8 ? z8 : z32;
  wire        ovf_v       = sel8 ? of8 : of32;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: plain unsigned and signed arithmetic on the accepted operands.
  function automatic void model(input int w, input longint av, input longint bv, input bit bi,
                                output longint d, output bit bo, output bit z, output bit ov);
    longint m, sa, sb, sr, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    bo   = av < (bv + bi);
    d    = (av - bv - bi) & m;
    z    = (d == 0);
    sa   = (av >= half) ? av - (longint'(1) << w) : av;
    sb   = (bv >= half) ? bv - (longint'(1) << w) : bv;
    sr   = sa - sb - bi;
    ov   = (sr < -half) || (sr > half - 1);
  endfunction

  longint exp_d;
  bit     exp_bo, exp_z, exp_ov;

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    int w, lat;
    w = sel8 ? 8 : 32;
    if (sel8) begin
      av = av & 32'hFF;
      bv = bv & 32'hFF;
    end
    model(w, longint'(av), longint'(bv), bi, exp_d, exp_bo, exp_z, exp_ov);
    chk("in_ready_idle", in_ready_v, 1);
    in_valid = 1'b1; a = av; b = bv; bin = bi;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    while (!out_valid_v && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, w / 8 + 1);
    chk("diff", diff_v, exp_d);
    chk("bout", bout_v, exp_bo);
    chk("zero", zero_v, exp_z);
    chk("ovf", ovf_v, exp_ov);
  endtask

  task automatic finish_op(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid_v, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid_v, 0);
    chk("in_ready_back", in_ready_v, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stray;
    logic [31:0] ra, rb;
    rst = 1'b1; sel8 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready32", ir32, 1);
    chk("rst_valid32", ov32, 0);
    chk("rst_diff32", d32, 0);
    chk("rst_flags32", {bo32, z32, of32}, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_valid8", ov8, 0);

    start_op(32'h0, 32'h1, 1'b0);
    chk("t1_diff", d32, 32'hFFFFFFFF);
    chk("t1_bout", bo32, 1);
    finish_op(0);

    start_op(32'h80000000, 32'h1, 1'b0);
    chk("t2_diff", d32, 32'h7FFFFFFF);
    chk("t2_ovf", of32, 1);
    finish_op(1);

    start_op(32'h12345678, 32'h12345678, 1'b0);
    chk("t3_zero", z32, 1);
    finish_op(0);

    start_op(32'h12345678, 32'h12345678, 1'b1);
    chk("t4_diff", d32, 32'hFFFFFFFF);
    chk("t4_bout", bo32, 1);
    finish_op(0);

    // Backpressure: result frozen while in_valid pulses and operands churn.
    start_op(32'hCAFE0123, 32'h00BEEF45, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", ov32, 1);
      chk("bp_in_ready", ir32, 0);
      chk("bp_diff", d32, exp_d);
    end
    in_valid = 1'b0;
    finish_op(0);
    stray = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (ov32) stray++;
    end
    chk("bp_no_extra", stray, 0);

    // Reset in the second RUN cycle discards the operation.
    in_valid = 1'b1; a = 32'h00001234; b = 32'h00000FFF; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", ov32, 0);
    chk("mid_rst_diff", d32, 0);
    chk("mid_rst_flags", {bo32, z32, of32}, 0);
    chk("mid_rst_in_ready", ir32, 1);
    stray = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (ov32) stray++;
    end
    chk("mid_rst_no_result", stray, 0);
    start_op(32'h10, 32'h3, 1'b0);
    chk("post_rst_diff", d32, 32'h0000000D);
    finish_op(0);

    for (int s = 0; s < 2; s++) begin
      sel8 = 1'(s);
      for (int n = 0; n < 500; n++) begin
        ra = $urandom;
        rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
        start_op(ra, rb, 1'($urandom));
        finish_op($urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
